// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS control unit.
//   - state_t : controller states
//   - OP_*    : supported IR[31:26] opcodes
//   - FN_*    : supported R-type IR[5:0] functs
//   - ALU_*   : aluop encodings, shared with the ALU
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXE,
    WB,
    MADR,
    MRD,
    MWB,
    MWR,
    BR,
    JMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;

  // True for the R-type functs this controller implements.
  function automatic logic rfunct_legal(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_ADDU) ||
           (funct == FN_SUBU) || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_aluop_dec.sv
// mc_aluop_dec: combinational ALU-control decode.
//   state     in  current controller state
//   op        in  IR[31:26]
//   funct     in  IR[5:0]
//   aluop     out ALU operation select
//   alu_src_b out 0 rt data, 1 extended immediate
//   ext_sign  out 1 sign-extend, 0 zero-extend
module mc_aluop_dec
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] aluop,
  output logic       alu_src_b,
  output logic       ext_sign
);

  always_comb begin
    aluop     = ALU_ADD;
    alu_src_b = 1'b0;
    ext_sign  = 1'b0;
    unique case (state)
      EXE: begin
        case (op)
          OP_RTYPE: begin
            case (funct)
              FN_SUBU: aluop = ALU_SUB;
              FN_SLT:  aluop = ALU_SLT;
              default: aluop = ALU_ADD;  // add, addu
            endcase
          end
          OP_ORI: begin
            aluop     = ALU_OR;
            alu_src_b = 1'b1;
          end
          OP_LUI: begin
            aluop     = ALU_LUI;
            alu_src_b = 1'b1;
          end
          default: aluop = ALU_ADD;
        endcase
      end
      MADR: begin
        aluop     = ALU_ADD;
        alu_src_b = 1'b1;
        ext_sign  = 1'b1;
      end
      BR: aluop = ALU_SUB;
      default: aluop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit (ALU-interface initiator).
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   op, funct  in  IR fields, valid from DECODE onward
//   zero       in  ALU result == 0
//   oflow      in  ALU signed-add overflow
//   aluop      out ALU operation
//   pc_wr      out PC load enable
//   npc_sel    out next-PC select (00 PC+4, 01 branch, 10 jump)
//   ir_wr      out IR load enable
//   reg_wr     out register-file write enable
//   reg_dst    out 0 rt, 1 rd
//   mem_to_reg out 0 ALUOut, 1 MDR
//   alu_src_b  out 0 rt data, 1 immediate
//   ext_sign   out 1 sign-extend, 0 zero-extend
//   mem_wr     out data-memory write enable
//   ovf        out pulse when an add result is discarded
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       oflow,
  output logic [2:0] aluop,
  output logic       pc_wr,
  output logic [1:0] npc_sel,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_b,
  output logic       ext_sign,
  output logic       mem_wr,
  output logic       ovf
);

  state_t state_reg;
  state_t state_next;
  logic   ovf_q;

  logic       is_add;
  logic [2:0] aluop_dec;
  logic       alu_src_b_dec;
  logic       ext_sign_dec;

  logic       pc_wr_dec;
  logic [1:0] npc_sel_dec;
  logic       ir_wr_dec;
  logic       reg_wr_dec;
  logic       reg_dst_dec;
  logic       mem_to_reg_dec;
  logic       mem_wr_dec;
  logic       ovf_dec;

  assign is_add = (op == OP_RTYPE) && (funct == FN_ADD);

  mc_aluop_dec u_aluop_dec (
    .state     (state_reg),
    .op        (op),
    .funct     (funct),
    .aluop     (aluop_dec),
    .alu_src_b (alu_src_b_dec),
    .ext_sign  (ext_sign_dec)
  );

  // Next-state logic.
  always_comb begin
    state_next = FETCH;
    unique case (state_reg)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:      state_next = rfunct_legal(funct) ? EXE : FETCH;
          OP_ORI, OP_LUI: state_next = EXE;
          OP_LW, OP_SW:  state_next = MADR;
          OP_BEQ:        state_next = BR;
          OP_J:          state_next = JMP;
          default:       state_next = FETCH;  // illegal: NOP
        endcase
      end
      EXE:  state_next = WB;
      MADR: state_next = (op == OP_LW) ? MRD : MWR;
      MRD:  state_next = MWB;
      default: state_next = FETCH;  // WB, MWB, MWR, BR, JMP
    endcase
  end

  // State register plus the overflow flag. ovf_q is loaded only while in
  // EXE, so the ALU overflow is sampled exactly once per add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      ovf_q     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == EXE) begin
        ovf_q <= is_add & oflow;
      end else if (state_reg == WB) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Enable decode: a function of state (and IR), except pc_wr in BR which
  // follows zero in the same cycle.
  always_comb begin
    pc_wr_dec      = 1'b0;
    npc_sel_dec    = 2'b00;
    ir_wr_dec      = 1'b0;
    reg_wr_dec     = 1'b0;
    reg_dst_dec    = 1'b0;
    mem_to_reg_dec = 1'b0;
    mem_wr_dec     = 1'b0;
    ovf_dec        = 1'b0;
    unique case (state_reg)
      FETCH: begin
        ir_wr_dec = 1'b1;
        pc_wr_dec = 1'b1;
      end
      WB: begin
        reg_wr_dec  = ~ovf_q;
        reg_dst_dec = (op == OP_RTYPE);
        ovf_dec     = ovf_q;
      end
      MWB: begin
        reg_wr_dec     = 1'b1;
        mem_to_reg_dec = 1'b1;
      end
      MWR: mem_wr_dec = 1'b1;
      BR: begin
        npc_sel_dec = 2'b01;
        pc_wr_dec   = zero;
      end
      JMP: begin
        npc_sel_dec = 2'b10;
        pc_wr_dec   = 1'b1;
      end
      default: ;
    endcase
  end

  // Holding rst_n low silences every output, including the FETCH enables
  // that the reset state would otherwise assert.
  assign aluop      = rst_n ? aluop_dec : 3'b000;
  assign alu_src_b  = rst_n & alu_src_b_dec;
  assign ext_sign   = rst_n & ext_sign_dec;
  assign pc_wr      = rst_n & pc_wr_dec;
  assign npc_sel    = rst_n ? npc_sel_dec : 2'b00;
  assign ir_wr      = rst_n & ir_wr_dec;
  assign reg_wr     = rst_n & reg_wr_dec;
  assign reg_dst    = rst_n & reg_dst_dec;
  assign mem_to_reg = rst_n & mem_to_reg_dec;
  assign mem_wr     = rst_n & mem_wr_dec;
  assign ovf        = rst_n & ovf_dec;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. Table-driven instruction
// vectors, hand-written reset sequences and randomized instructions, all
// compared cycle by cycle against an instruction-level timeline model.
module tb_mc_ctrl;

  typedef struct packed {
    logic [2:0] aluop;
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       ir_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_b;
    logic       ext_sign;
    logic       mem_wr;
    logic       ovf;
  } out_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic [7:0] zpat;
    logic [7:0] opat;
    int         cycles;
    int         n_reg;
    int         n_mem;
    int         n_ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       oflow;
  logic [2:0] aluop;
  logic       pc_wr;
  logic [1:0] npc_sel;
  logic       ir_wr;
  logic       reg_wr;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_b;
  logic       ext_sign;
  logic       mem_wr;
  logic       ovf;

  out_t dut_out;
  out_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .oflow      (oflow),
    .aluop      (aluop),
    .pc_wr      (pc_wr),
    .npc_sel    (npc_sel),
    .ir_wr      (ir_wr),
    .reg_wr     (reg_wr),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .ext_sign   (ext_sign),
    .mem_wr     (mem_wr),
    .ovf        (ovf)
  );

  assign dut_out = {aluop, pc_wr, npc_sel, ir_wr, reg_wr, reg_dst,
                    mem_to_reg, alu_src_b, ext_sign, mem_wr, ovf};

  task automatic check_out(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Instruction-level model: the expected output of every cycle of one
  // instruction, from FETCH up to (not including) the next FETCH.
  task automatic build_model(input logic [5:0] iop, input logic [5:0] ifn,
                             input logic [7:0] zpat, input logic [7:0] opat);
    out_t o;
    bit   legal_r;
    bit   dropped;
    exp_q.delete();
    o = '0; o.ir_wr = 1'b1; o.pc_wr = 1'b1; exp_q.push_back(o);
    o = '0; exp_q.push_back(o);
    legal_r = (iop == 6'h00) && (ifn inside {6'h20, 6'h21, 6'h23, 6'h2A});
    if (legal_r || iop == 6'h0D || iop == 6'h0F) begin
      o = '0;
      if (iop == 6'h0D)      o.aluop = 3'b001;
      else if (iop == 6'h0F) o.aluop = 3'b100;
      else if (ifn == 6'h23) o.aluop = 3'b011;
      else if (ifn == 6'h2A) o.aluop = 3'b010;
      else                   o.aluop = 3'b000;
      o.alu_src_b = (iop != 6'h00);
      exp_q.push_back(o);
      dropped = legal_r && (ifn == 6'h20) && opat[2];
      o = '0; o.reg_wr = !dropped; o.reg_dst = (iop == 6'h00); o.ovf = dropped;
      exp_q.push_back(o);
    end else if (iop == 6'h23 || iop == 6'h2B) begin
      o = '0; o.alu_src_b = 1'b1; o.ext_sign = 1'b1; exp_q.push_back(o);
      if (iop == 6'h23) begin
        o = '0; exp_q.push_back(o);
        o = '0; o.reg_wr = 1'b1; o.mem_to_reg = 1'b1; exp_q.push_back(o);
      end else begin
        o = '0; o.mem_wr = 1'b1; exp_q.push_back(o);
      end
    end else if (iop == 6'h04) begin
      o = '0; o.aluop = 3'b011; o.npc_sel = 2'b01; o.pc_wr = zpat[2];
      exp_q.push_back(o);
    end else if (iop == 6'h02) begin
      o = '0; o.npc_sel = 2'b10; o.pc_wr = 1'b1; exp_q.push_back(o);
    end
  endtask

  // Runs one instruction starting in its FETCH cycle (called just after a
  // rising edge). Stops at the next FETCH, or after stop_after cycles when
  // stop_after > 0 (used to abort with reset).
  task automatic exec(input string name, input logic [5:0] iop, input logic [5:0] ifn,
                      input logic [7:0] zpat, input logic [7:0] opat, input int stop_after,
                      output int ncyc, output int nreg, output int nmem, output int novf);
    int k = 0;
    bit done = 0;
    build_model(iop, ifn, zpat, opat);
    ncyc = 0; nreg = 0; nmem = 0; novf = 0;
    while (!done) begin
      op    = (k == 0) ? 6'($urandom) : iop;
      funct = (k == 0) ? 6'($urandom) : ifn;
      zero  = zpat[k % 8];
      oflow = opat[k % 8];
      #1;
      if (k > 0 && ir_wr) begin
        ncyc = k;
        done = 1;
      end else if (k >= 10) begin
        check_int({name, "_timeout"}, k, exp_q.size());
        ncyc = k;
        done = 1;
      end else begin
        if (k < exp_q.size())
          check_out($sformatf("%s_c%0d", name, k), dut_out, exp_q[k]);
        else
          check_int($sformatf("%s_extra_c%0d", name, k), k, exp_q.size() - 1);
        nreg += int'(reg_wr);
        nmem += int'(mem_wr);
        novf += int'(ovf);
        if (stop_after > 0 && k + 1 == stop_after) begin
          ncyc = k + 1;
          done = 1;
        end else begin
          @(posedge clk);
          #1;
          k++;
        end
      end
    end
    $display("instr %s op=%h funct=%h cycles=%0d reg_wr=%0d mem_wr=%0d ovf=%0d",
             name, iop, ifn, ncyc, nreg, nmem, novf);
  endtask

  // Assert reset mid-cycle, hold it across an edge, release mid-cycle.
  task automatic reset_pulse(input string name);
    out_t fetch_o;
    fetch_o = '0; fetch_o.ir_wr = 1'b1; fetch_o.pc_wr = 1'b1;
    zero = 1'b1; oflow = 1'b1;
    rst_n = 1'b0;
    #1;
    check_out({name, "_async"}, dut_out, '0);
    @(posedge clk);
    #1;
    check_out({name, "_held"}, dut_out, '0);
    rst_n = 1'b1;
    #1;
    check_out({name, "_release_fetch"}, dut_out, fetch_o);
  endtask

  initial begin
    vec_t vecs[$];
    int ncyc, nreg, nmem, novf;
    logic [5:0] iop, ifn;

    vecs.push_back('{"addu",       6'h00, 6'h21, 8'h00, 8'h00, 4, 1, 0, 0});
    vecs.push_back('{"add_oflow",  6'h00, 6'h20, 8'h00, 8'h04, 4, 0, 0, 1});
    vecs.push_back('{"add_ok",     6'h00, 6'h20, 8'h00, 8'hFB, 4, 1, 0, 0});
    vecs.push_back('{"addu_oflow", 6'h00, 6'h21, 8'h00, 8'hFF, 4, 1, 0, 0});
    vecs.push_back('{"subu",       6'h00, 6'h23, 8'h00, 8'h00, 4, 1, 0, 0});
    vecs.push_back('{"slt",        6'h00, 6'h2A, 8'h00, 8'h00, 4, 1, 0, 0});
    vecs.push_back('{"ori",        6'h0D, 6'h15, 8'h00, 8'h00, 4, 1, 0, 0});
    vecs.push_back('{"lui",        6'h0F, 6'h3F, 8'h00, 8'h00, 4, 1, 0, 0});
    vecs.push_back('{"lw",         6'h23, 6'h00, 8'h00, 8'h00, 5, 1, 0, 0});
    vecs.push_back('{"sw",         6'h2B, 6'h00, 8'h00, 8'h00, 4, 0, 1, 0});
    vecs.push_back('{"beq_taken",  6'h04, 6'h00, 8'h04, 8'h00, 3, 0, 0, 0});
    vecs.push_back('{"beq_not",    6'h04, 6'h00, 8'hFB, 8'h00, 3, 0, 0, 0});
    vecs.push_back('{"j",          6'h02, 6'h00, 8'h00, 8'h00, 3, 0, 0, 0});
    vecs.push_back('{"illegal_op", 6'h3F, 6'h20, 8'h00, 8'h00, 2, 0, 0, 0});
    vecs.push_back('{"illegal_fn", 6'h00, 6'h22, 8'h00, 8'h00, 2, 0, 0, 0});

    // Reset state: everything 0 while rst_n is low.
    rst_n = 1'b0; op = 6'h23; funct = 6'h20; zero = 1'b1; oflow = 1'b1;
    #2;
    check_out("reset_outputs", dut_out, '0);
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_outputs_held", dut_out, '0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      exec(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zpat, vecs[i].opat, 0,
           ncyc, nreg, nmem, novf);
      check_int({vecs[i].name, "_cycles"}, ncyc, vecs[i].cycles);
      check_int({vecs[i].name, "_reg_wr"}, nreg, vecs[i].n_reg);
      check_int({vecs[i].name, "_mem_wr"}, nmem, vecs[i].n_mem);
      check_int({vecs[i].name, "_ovf"},    novf, vecs[i].n_ovf);
    end

    // Reset while in MWB of a lw: the write must not complete.
    exec("lw_abort", 6'h23, 6'h00, 8'h00, 8'h00, 5, ncyc, nreg, nmem, novf);
    reset_pulse("rst_mwb");
    exec("ori_after_rst", 6'h0D, 6'h00, 8'h00, 8'h00, 0, ncyc, nreg, nmem, novf);
    check_int("ori_after_rst_cycles", ncyc, 4);
    check_int("ori_after_rst_reg_wr", nreg, 1);

    // Reset while WB shows a dropped add: the overflow flag must not leak
    // into the following instruction.
    exec("add_abort", 6'h00, 6'h20, 8'h00, 8'h04, 4, ncyc, nreg, nmem, novf);
    check_int("add_abort_ovf", novf, 1);
    reset_pulse("rst_wb");
    exec("lui_after_rst", 6'h0F, 6'h00, 8'h00, 8'h00, 0, ncyc, nreg, nmem, novf);
    check_int("lui_after_rst_reg_wr", nreg, 1);
    check_int("lui_after_rst_ovf", novf, 0);

    // Randomized instructions against the model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: iop = 6'h00;
        1: iop = 6'h0D;
        2: iop = 6'h0F;
        3: iop = 6'h23;
        4: iop = 6'h2B;
        5: iop = 6'h04;
        6: iop = 6'h02;
        default: iop = 6'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: ifn = 6'h20;
        1: ifn = 6'h21;
        2: ifn = 6'h23;
        3: ifn = 6'h2A;
        default: ifn = 6'($urandom);
      endcase
      exec($sformatf("rnd%0d", n), iop, ifn, 8'($urandom), 8'($urandom), 0,
           ncyc, nreg, nmem, novf);
      check_int($sformatf("rnd%0d_cycles", n), ncyc, exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
